// File: rtl/gshare_pht_if.sv
// -----------------------------------------------------------------------------
// gshare_pht_if
//
// Purpose:
//   Groups the FETCH-side lookup signals and the DECODE-side resolve signals of
//   the gshare pattern history table into one bundle.
//
// Handshake semantics:
//   There is no ready/backpressure path. lookup_valid and update_valid are
//   qualifiers only: a lookup or resolve is taken on a rising clk edge exactly
//   when its valid is high and the table's en input is high. The table's
//   outputs (pred, pred_hit, mispredict, ghr) are always driven and are
//   meaningful in any cycle where the matching valid is high.
//
// Signals:
//   lookup_valid  master->slave  instr in FETCH is a branch
//   lookup_pc     master->slave  PC bits used for indexing (IWIDTH)
//   fallback      master->slave  static default prediction for that instr
//   pred          slave->master  direction prediction
//   pred_hit      slave->master  indexed table entry is valid
//   update_valid  master->slave  instr in DECODE is a resolved branch
//   update_taken  master->slave  actual outcome of that branch
//   mispredict    slave->master  resolved outcome differs from checkpoint
//   ghr           slave->master  speculative global history (HWIDTH)
//
// Modports:
//   master : pipeline side (drives lookup/update requests)
//   slave  : predictor side (gshare_pht)
// -----------------------------------------------------------------------------
interface gshare_pht_if #(
    parameter int IWIDTH = 6,
    parameter int HWIDTH = 4
) ();
    logic              lookup_valid;
    logic [IWIDTH-1:0] lookup_pc;
    logic              fallback;
    logic              pred;
    logic              pred_hit;
    logic              update_valid;
    logic              update_taken;
    logic              mispredict;
    logic [HWIDTH-1:0] ghr;

    modport master (
        output lookup_valid,
        output lookup_pc,
        output fallback,
        output update_valid,
        output update_taken,
        input  pred,
        input  pred_hit,
        input  mispredict,
        input  ghr
    );

    modport slave (
        input  lookup_valid,
        input  lookup_pc,
        input  fallback,
        input  update_valid,
        input  update_taken,
        output pred,
        output pred_hit,
        output mispredict,
        output ghr
    );
endinterface

// File: rtl/gshare_pht.sv
// -----------------------------------------------------------------------------
// gshare_pht
//
// Purpose:
//   Direction predictor placed between FETCH (lookup) and DECODE (resolve).
//   A table of 2**IWIDTH saturating counters with per-entry valid bits is
//   indexed by a hash of the fetch PC and a speculative global history
//   register (GHR). One branch is in flight: each lookup leaves a checkpoint
//   (index, prediction, pre-shift history) that the next cycle's resolve
//   consumes to train the counter and, on a mispredict, repair the GHR.
//
// Parameters:
//   IWIDTH  table index width (2**IWIDTH entries)
//   HWIDTH  global history length, 1..IWIDTH (MODE 2 needs HWIDTH < IWIDTH)
//   CWIDTH  saturating counter width, >= 2
//   MODE    index hash: 0 = pc, 1 = pc ^ zero-extended ghr,
//           2 = {pc[IWIDTH-HWIDTH-1:0], ghr}
//
// Ports:
//   clk               clock
//   reset             asynchronous, active-high reset
//   en                pipeline advance; when low no state changes
//   bus (slave)       lookup/resolve bundle, see gshare_pht_if
//   stat_lookups      (GSHARE_PHT_STATS_EN only) count of taken lookups
//   stat_hits         (GSHARE_PHT_STATS_EN only) count of taken lookups that hit
//   stat_mispredicts  (GSHARE_PHT_STATS_EN only) count of mispredicts while en
//
// Build options:
//   GSHARE_PHT_STATS_EN  when defined, adds the three 32-bit wrapping
//                        statistics counters and their output ports.
// -----------------------------------------------------------------------------
module gshare_pht #(
    parameter int IWIDTH = 6,
    parameter int HWIDTH = 4,
    parameter int CWIDTH = 2,
    parameter int MODE   = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    gshare_pht_if.slave bus
`ifdef GSHARE_PHT_STATS_EN
    ,
    output logic [31:0] stat_lookups,
    output logic [31:0] stat_hits,
    output logic [31:0] stat_mispredicts
`endif
);

    localparam int ENTRIES = 1 << IWIDTH;

    // Allocation seeds: weakly taken is 10..0, weakly not-taken is 01..1.
    localparam logic [CWIDTH-1:0] CNT_WT  = {1'b1, {(CWIDTH-1){1'b0}}};
    localparam logic [CWIDTH-1:0] CNT_WNT = {1'b0, {(CWIDTH-1){1'b1}}};
    localparam logic [CWIDTH-1:0] CNT_MAX = {CWIDTH{1'b1}};
    localparam logic [CWIDTH-1:0] CNT_MIN = {CWIDTH{1'b0}};

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [ENTRIES-1:0] valid_q;
    logic [ENTRIES-1:0] valid_d;
    logic [CWIDTH-1:0]  cnt_q [ENTRIES];
    logic [CWIDTH-1:0]  cnt_d [ENTRIES];

    logic [HWIDTH-1:0]  ghr_q;
    logic [HWIDTH-1:0]  ghr_d;

    // Checkpoint of the lookup currently travelling to DECODE.
    logic [IWIDTH-1:0]  last_idx_q;
    logic [IWIDTH-1:0]  last_idx_d;
    logic               last_pred_q;
    logic               last_pred_d;
    logic [HWIDTH-1:0]  last_ghr_q;
    logic [HWIDTH-1:0]  last_ghr_d;
    logic               last_valid_q;
    logic               last_valid_d;

    // -------------------------------------------------------------------------
    // Combinational datapath
    // -------------------------------------------------------------------------
    logic [IWIDTH-1:0]  idx;
    logic               hit;
    logic               pred;
    logic               mispredict;
    logic [HWIDTH-1:0]  ghr_spec;
    logic [HWIDTH-1:0]  ghr_fix;
    logic               do_lookup;
    logic               do_alloc;
    logic               do_update;

    // Index hash. Only the selected variant is elaborated so the MODE 2 slice
    // never exists when HWIDTH == IWIDTH.
    generate
        if (MODE == 0) begin : g_hash_pc
            assign idx = bus.lookup_pc;
        end else if (MODE == 1) begin : g_hash_xor
            logic [IWIDTH-1:0] ghr_ext;
            always_comb begin
                ghr_ext               = '0;
                ghr_ext[HWIDTH-1:0]   = ghr_q;
            end
            assign idx = bus.lookup_pc ^ ghr_ext;
        end else begin : g_hash_cat
            logic unused_pc_hi;
            assign idx          = {bus.lookup_pc[IWIDTH-HWIDTH-1:0], ghr_q};
            assign unused_pc_hi = ^bus.lookup_pc[IWIDTH-1:IWIDTH-HWIDTH];
        end
    endgenerate

    // Reads see the pre-edge table; a same-cycle update is not bypassed.
    assign hit  = valid_q[idx];
    assign pred = hit ? cnt_q[idx][CWIDTH-1] : bus.fallback;

    // Only a live checkpoint can be judged; a stray resolve is ignored.
    assign mispredict = bus.update_valid & last_valid_q &
                        (bus.update_taken != last_pred_q);

    assign do_lookup = en & bus.lookup_valid;
    assign do_alloc  = do_lookup & ~hit;
    assign do_update = en & bus.update_valid & last_valid_q;

    // History shift (speculative, from this cycle's prediction) and repair
    // (from the checkpointed pre-shift history plus the real outcome).
    generate
        if (HWIDTH == 1) begin : g_ghr_1
            logic unused_last_ghr;
            assign ghr_spec        = pred;
            assign ghr_fix         = bus.update_taken;
            assign unused_last_ghr = last_ghr_q[0];
        end else begin : g_ghr_n
            logic unused_last_ghr_msb;
            assign ghr_spec            = {ghr_q[HWIDTH-2:0], pred};
            assign ghr_fix             = {last_ghr_q[HWIDTH-2:0], bus.update_taken};
            assign unused_last_ghr_msb = last_ghr_q[HWIDTH-1];
        end
    endgenerate

    // Saturating +/-1 step of a counter.
    function automatic logic [CWIDTH-1:0] sat_step(
        input logic [CWIDTH-1:0] c,
        input logic              up
    );
        logic [CWIDTH-1:0] r;
        r = c;
        if (up) begin
            if (c != CNT_MAX) r = c + CWIDTH'(1);
        end else begin
            if (c != CNT_MIN) r = c - CWIDTH'(1);
        end
        return r;
    endfunction

    // -------------------------------------------------------------------------
    // Next-state: table
    // -------------------------------------------------------------------------
    always_comb begin
        valid_d = valid_q;
        cnt_d   = cnt_q;
        if (do_alloc) begin
            valid_d[idx] = 1'b1;
            cnt_d[idx]   = bus.fallback ? CNT_WT : CNT_WNT;
        end
        // Written after the allocation so that, if both target the same
        // entry, the trained value (from the pre-edge counter) is kept.
        if (do_update) begin
            cnt_d[last_idx_q] = sat_step(cnt_q[last_idx_q], bus.update_taken);
        end
    end

    // -------------------------------------------------------------------------
    // Next-state: history and checkpoint
    // -------------------------------------------------------------------------
    always_comb begin
        ghr_d = ghr_q;
        if (en) begin
            // Repair overrides the wrong-path speculative shift.
            if (mispredict) begin
                ghr_d = ghr_fix;
            end else if (bus.lookup_valid) begin
                ghr_d = ghr_spec;
            end
        end
    end

    always_comb begin
        last_idx_d   = last_idx_q;
        last_pred_d  = last_pred_q;
        last_ghr_d   = last_ghr_q;
        last_valid_d = last_valid_q;
        if (do_lookup) begin
            last_idx_d   = idx;
            last_pred_d  = pred;
            last_ghr_d   = ghr_q;
            last_valid_d = 1'b1;
        end else if (en) begin
            // A bubble in FETCH means nothing reaches DECODE next cycle.
            last_valid_d = 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q      <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                cnt_q[i] <= '0;
            end
            ghr_q        <= '0;
            last_idx_q   <= '0;
            last_pred_q  <= 1'b0;
            last_ghr_q   <= '0;
            last_valid_q <= 1'b0;
        end else begin
            valid_q      <= valid_d;
            cnt_q        <= cnt_d;
            ghr_q        <= ghr_d;
            last_idx_q   <= last_idx_d;
            last_pred_q  <= last_pred_d;
            last_ghr_q   <= last_ghr_d;
            last_valid_q <= last_valid_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign bus.pred       = pred;
    assign bus.pred_hit   = hit;
    assign bus.mispredict = mispredict;
    assign bus.ghr        = ghr_q;

`ifdef GSHARE_PHT_STATS_EN
    // -------------------------------------------------------------------------
    // Statistics (free-running, wrap at 2**32)
    // -------------------------------------------------------------------------
    logic [31:0] stat_lookups_q;
    logic [31:0] stat_lookups_d;
    logic [31:0] stat_hits_q;
    logic [31:0] stat_hits_d;
    logic [31:0] stat_mispredicts_q;
    logic [31:0] stat_mispredicts_d;

    always_comb begin
        stat_lookups_d     = stat_lookups_q;
        stat_hits_d        = stat_hits_q;
        stat_mispredicts_d = stat_mispredicts_q;
        if (do_lookup)        stat_lookups_d     = stat_lookups_q + 32'd1;
        if (do_lookup & hit)  stat_hits_d        = stat_hits_q + 32'd1;
        if (en & mispredict)  stat_mispredicts_d = stat_mispredicts_q + 32'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_lookups_q     <= '0;
            stat_hits_q        <= '0;
            stat_mispredicts_q <= '0;
        end else begin
            stat_lookups_q     <= stat_lookups_d;
            stat_hits_q        <= stat_hits_d;
            stat_mispredicts_q <= stat_mispredicts_d;
        end
    end

    assign stat_lookups     = stat_lookups_q;
    assign stat_hits        = stat_hits_q;
    assign stat_mispredicts = stat_mispredicts_q;
`endif

endmodule

// File: tb/tb_gshare_pht.sv
// -----------------------------------------------------------------------------
// tb_gshare_pht
//
// Three predictors (MODE 0, 1, 2; IWIDTH=6, HWIDTH=4, CWIDTH=2) share one
// set of stimulus wires and one reset. Each directed vector names the
// instance it targets and carries hand-computed pred / pred_hit /
// mispredict / ghr values; the driver queues them and a negedge monitor pops
// and compares whenever a lookup or resolve is presented.
// -----------------------------------------------------------------------------
module tb_gshare_pht;

    localparam int IW = 6;
    localparam int HW = 4;
    localparam int W  = 9;   // {sel[1:0], pred, hit, mispredict, ghr[3:0]}

    // ---------------------------------------------------------------- clock/reset
    logic clk;
    logic reset;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------------------------------------------------------- stimulus wires
    logic          en;
    logic          lv;
    logic [IW-1:0] pc;
    logic          fb;
    logic          uv;
    logic          ut;

    gshare_pht_if #(.IWIDTH(IW), .HWIDTH(HW)) if_m0 ();
    gshare_pht_if #(.IWIDTH(IW), .HWIDTH(HW)) if_m1 ();
    gshare_pht_if #(.IWIDTH(IW), .HWIDTH(HW)) if_m2 ();

    assign if_m0.lookup_valid = lv;
    assign if_m0.lookup_pc    = pc;
    assign if_m0.fallback     = fb;
    assign if_m0.update_valid = uv;
    assign if_m0.update_taken = ut;
    assign if_m1.lookup_valid = lv;
    assign if_m1.lookup_pc    = pc;
    assign if_m1.fallback     = fb;
    assign if_m1.update_valid = uv;
    assign if_m1.update_taken = ut;
    assign if_m2.lookup_valid = lv;
    assign if_m2.lookup_pc    = pc;
    assign if_m2.fallback     = fb;
    assign if_m2.update_valid = uv;
    assign if_m2.update_taken = ut;

`ifdef GSHARE_PHT_STATS_EN
    logic [31:0] s_lk [3];
    logic [31:0] s_ht [3];
    logic [31:0] s_mp [3];
`endif

    gshare_pht #(.IWIDTH(IW), .HWIDTH(HW), .CWIDTH(2), .MODE(0)) u_m0 (
        .clk              (clk),
        .reset            (reset),
        .en               (en),
        .bus              (if_m0)
`ifdef GSHARE_PHT_STATS_EN
        ,
        .stat_lookups     (s_lk[0]),
        .stat_hits        (s_ht[0]),
        .stat_mispredicts (s_mp[0])
`endif
    );

    gshare_pht #(.IWIDTH(IW), .HWIDTH(HW), .CWIDTH(2), .MODE(1)) u_m1 (
        .clk              (clk),
        .reset            (reset),
        .en               (en),
        .bus              (if_m1)
`ifdef GSHARE_PHT_STATS_EN
        ,
        .stat_lookups     (s_lk[1]),
        .stat_hits        (s_ht[1]),
        .stat_mispredicts (s_mp[1])
`endif
    );

    gshare_pht #(.IWIDTH(IW), .HWIDTH(HW), .CWIDTH(2), .MODE(2)) u_m2 (
        .clk              (clk),
        .reset            (reset),
        .en               (en),
        .bus              (if_m2)
`ifdef GSHARE_PHT_STATS_EN
        ,
        .stat_lookups     (s_lk[2]),
        .stat_hits        (s_ht[2]),
        .stat_mispredicts (s_mp[2])
`endif
    );

    // ---------------------------------------------------------------- scoreboard
    logic [W-1:0] exp_q[$];
    int           n_cmp  = 0;
    int           n_fail = 0;
    int           n_vec  = 0;

    task automatic check_field(input string name, input int vec,
                               input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s vec %0d: got %0h, expected %0h", name, vec, act, exp);
        end
    endtask

    // ---------------------------------------------------------------- monitor
    logic [W-1:0] mon_e;
    logic [6:0]   mon_act;

    always @(negedge clk) begin
        if (!reset && (lv || uv)) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_output: got an output with no queued expectation, expected none");
            end else begin
                mon_e = exp_q.pop_front();
                n_vec++;
                case (mon_e[8:7])
                    2'd0:    mon_act = {if_m0.pred, if_m0.pred_hit, if_m0.mispredict, if_m0.ghr};
                    2'd1:    mon_act = {if_m1.pred, if_m1.pred_hit, if_m1.mispredict, if_m1.ghr};
                    default: mon_act = {if_m2.pred, if_m2.pred_hit, if_m2.mispredict, if_m2.ghr};
                endcase
                check_field("pred",       n_vec, 32'(mon_act[6]),   32'(mon_e[6]));
                check_field("pred_hit",   n_vec, 32'(mon_act[5]),   32'(mon_e[5]));
                check_field("mispredict", n_vec, 32'(mon_act[4]),   32'(mon_e[4]));
                check_field("ghr",        n_vec, 32'(mon_act[3:0]), 32'(mon_e[3:0]));
            end
        end
    end

    // ---------------------------------------------------------------- driver tasks
    task automatic do_reset();
        @(posedge clk);
        #1;
        en    = 1'b0;
        lv    = 1'b0;
        uv    = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // One cycle of stimulus plus the expected outputs for instance sel.
    task automatic drive(input logic [1:0] sel, input logic e, input logic l,
                         input logic [IW-1:0] pc_v, input logic fb_v,
                         input logic u, input logic ut_v,
                         input logic ep, input logic eh, input logic em,
                         input logic [HW-1:0] eg);
        @(posedge clk);
        #1;
        en = e;
        lv = l;
        pc = pc_v;
        fb = fb_v;
        uv = u;
        ut = ut_v;
        if (l || u) exp_q.push_back({sel, ep, eh, em, eg});
    endtask

    // ---------------------------------------------------------------- watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------------------------------------------------------- main sequence
    initial begin
        reset = 1'b1;
        en    = 1'b0;
        lv    = 1'b0;
        pc    = '0;
        fb    = 1'b0;
        uv    = 1'b0;
        ut    = 1'b0;

        // MODE 0: reset state, ignored resolve, allocation seed, training.
        do_reset();
        drive(2'd0, 1'b0, 1'b1, 6'd5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000);
        drive(2'd0, 1'b0, 1'b1, 6'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
        drive(2'd0, 1'b1, 1'b0, 6'd5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);
        drive(2'd0, 1'b1, 1'b1, 6'd5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000);
        drive(2'd0, 1'b1, 1'b1, 6'd5, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 4'b0001);
        drive(2'd0, 1'b1, 1'b0, 6'd5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000);
        // Saturation on pc=3, then two not-taken resolves.
        drive(2'd0, 1'b1, 1'b1, 6'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000);
        drive(2'd0, 1'b1, 1'b1, 6'd3, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0001);
        drive(2'd0, 1'b1, 1'b1, 6'd3, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0011);
        drive(2'd0, 1'b1, 1'b1, 6'd3, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0111);
        drive(2'd0, 1'b1, 1'b1, 6'd3, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'b1111);
        drive(2'd0, 1'b1, 1'b1, 6'd3, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 4'b1111);
        drive(2'd0, 1'b1, 1'b1, 6'd3, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 4'b1110);
        drive(2'd0, 1'b1, 1'b1, 6'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b1110);

        // MODE 1: build ghr=1010, pc=0x0F lands on entry 0x05, re-read via pc=0.
        do_reset();
        drive(2'd1, 1'b1, 1'b1, 6'h20, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000);
        drive(2'd1, 1'b1, 1'b1, 6'h22, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0001);
        drive(2'd1, 1'b1, 1'b1, 6'h24, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0010);
        drive(2'd1, 1'b1, 1'b1, 6'h28, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0101);
        drive(2'd1, 1'b1, 1'b1, 6'h0F, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b1010);
        drive(2'd1, 1'b1, 1'b1, 6'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0101);

        // MODE 2: ghr=1001, pc=0x23 -> entry 0x39 (seeded not-taken), rebuild and re-read.
        do_reset();
        drive(2'd2, 1'b1, 1'b1, 6'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000);
        drive(2'd2, 1'b1, 1'b1, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0001);
        drive(2'd2, 1'b1, 1'b1, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0010);
        drive(2'd2, 1'b1, 1'b1, 6'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0100);
        drive(2'd2, 1'b1, 1'b1, 6'h23, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1001);
        drive(2'd2, 1'b1, 1'b1, 6'h01, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0010);
        drive(2'd2, 1'b1, 1'b1, 6'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0101);
        drive(2'd2, 1'b1, 1'b1, 6'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1010);
        drive(2'd2, 1'b1, 1'b1, 6'h01, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0100);
        drive(2'd2, 1'b1, 1'b1, 6'h23, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b1001);

        // MODE 0: reset discards checkpoint, mispredict repair, en=0 hold.
        do_reset();
        drive(2'd0, 1'b1, 1'b0, 6'h10, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);
        drive(2'd0, 1'b1, 1'b1, 6'h10, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000);
        drive(2'd0, 1'b1, 1'b1, 6'h11, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0001);
        drive(2'd0, 1'b1, 1'b1, 6'h12, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0011);
        drive(2'd0, 1'b1, 1'b1, 6'h13, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0111);
        drive(2'd0, 1'b1, 1'b1, 6'h13, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0110);
        drive(2'd0, 1'b1, 1'b1, 6'h12, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b1101);
        drive(2'd0, 1'b0, 1'b1, 6'h14, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b1010);
        drive(2'd0, 1'b0, 1'b1, 6'h14, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b1010);
        drive(2'd0, 1'b0, 1'b1, 6'h14, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b1010);
`ifdef GSHARE_PHT_STATS_EN
        @(negedge clk);
        check_field("stat_lookups",     0, s_lk[0], 32'd6);
        check_field("stat_hits",        0, s_ht[0], 32'd2);
        check_field("stat_mispredicts", 0, s_mp[0], 32'd1);
`endif
        drive(2'd0, 1'b1, 1'b1, 6'h14, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1010);

        // Drain and report.
        @(posedge clk);
        #1;
        lv = 1'b0;
        uv = 1'b0;
        en = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected outputs never observed, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/gshare_pht.md
Name: gshare_pht

Overview:
Parametrised successor to the direction-only pattern history table. It adds:
- a speculative global history register (GHR);
- selectable index hashing (PC-only, gshare XOR, gselect concat);
- configurable saturating-counter width;
- a mispredict output and GHR repair.

It sits between FETCH (lookup) and DECODE (resolve/update) of the branch-predict pipeline, one branch in flight.

Parameters:
IWIDTH, 6, table index width; table has 2**IWIDTH entries
HWIDTH, 4, global history length in bits; must be 1..IWIDTH (MODE 2 requires HWIDTH < IWIDTH)
CWIDTH, 2, saturating counter width; must be >= 2
MODE, 1, index hash: 0 = pc only, 1 = pc XOR zero-extended ghr, 2 = {pc[IWIDTH-HWIDTH-1:0], ghr}

Ports:
clk  in  1  clock
reset  in  1  reset, asynchronous, active-high
en  in  1  pipeline advance; when low, no state changes
lookup_valid  in  1  instr in FETCH is a branch
lookup_pc  in  IWIDTH  PC bits used for indexing
fallback  in  1  static default prediction for the FETCH instr
pred  out  1  prediction: counter MSB on hit, else fallback
pred_hit  out  1  indexed entry is valid
update_valid  in  1  instr in DECODE is a branch with a resolved outcome
update_taken  in  1  actual outcome of that branch
mispredict  out  1  update_valid & last_valid & (update_taken != last_pred)
ghr  out  HWIDTH  current speculative history, newest outcome in bit 0

Behaviour:
- Index (combinational): idx = hash(lookup_pc, ghr) per MODE. pred and pred_hit are combinational from the pre-clock table state; there is no bypass of a same-cycle update.
- Storage:
  - valid[2**IWIDTH];
  - cnt[2**IWIDTH] of CWIDTH bits;
  - checkpoint registers last_idx, last_pred, last_ghr, last_valid.
- Reset (async): all cnt = 0, valid = 0, ghr = 0, last_* = 0. With valid = 0, outputs are pred = fallback, pred_hit = 0, mispredict = 0.
- On clock edge with en=1 and lookup_valid=1:
  - capture last_idx = idx, last_pred = pred, last_ghr = ghr, last_valid = 1;
  - shift ghr <= {ghr[HWIDTH-2:0], pred} (speculative);
  - on miss, allocate: valid[idx] = 1; cnt[idx] = fallback ? 2**(CWIDTH-1) : 2**(CWIDTH-1)-1 (weakly taken / weakly not-taken).
- On clock edge with en=1 and lookup_valid=0: last_valid is cleared. The checkpoint is consumed and ghr is held.
- On clock edge with en=1, update_valid=1 and last_valid=1:
  - counter update: cnt[last_idx] +1 if taken, -1 if not, saturating at 0 and 2**CWIDTH-1;
  - update_valid with last_valid=0 is ignored (no counter change, mispredict=0).
- Repair: if mispredict, ghr <= {last_ghr[HWIDTH-2:0], update_taken}. This overrides any speculative shift in the same cycle; the wrong-path lookup's allocation still occurs.
- Simultaneous update and allocate to the same entry (last_idx == idx): the update wins, computed from the pre-edge cnt.
- en=0: all registers hold; outputs remain combinational.
- Reset mid-operation: everything returns to the reset state immediately, and in-flight checkpoints are discarded.

Optional Feature:
Macro GSHARE_PHT_STATS_EN.
- Defined: adds three 32-bit outputs that clear on reset and wrap at 2**32:
  - stat_lookups: +1 per en&lookup_valid;
  - stat_hits: +1 per en&lookup_valid&pred_hit;
  - stat_mispredicts: +1 per en&mispredict.
- Undefined: these ports and their counters do not exist; the rest of the behaviour is identical.

Test Plan:
1. Reset, then lookup pc=5, fallback=1, MODE 0 -> pred=1, pred_hit=0. Next cycle the entry is valid with cnt=2 and ghr=4'b0001.
2. CWIDTH=2, MODE 0. Repeated lookup pc=3 + update taken for 4 branches -> cnt[3] saturates at 3, pred=1, mispredict never asserted. Then 2 not-taken updates -> cnt=1, pred=0.
3. MODE 1, ghr=4'b1010, lookup_pc=6'h0F -> entry idx=6'h05 allocated/read.
4. MODE 2, IWIDTH=6, HWIDTH=4, pc=6'h23, ghr=4'h9 -> idx=6'h39.
5. Mispredict with fallback=1 and speculative ghr 0011->0111. Resolve update_taken=0 while a new lookup is in the same cycle -> mispredict=1 and ghr=0110. The wrong-path allocation still appears in valid.
6. update_valid pulse with no prior lookup after reset -> no cnt change, mispredict=0. Hold en=0 for 3 cycles with lookup_valid=1 -> ghr and table unchanged. With GSHARE_PHT_STATS_EN defined, the stat counters are also unchanged.
